ddr_deserializer: RTL and testbench
===================================

Name: ddr_deserializer

Overview:
- Receive side of the dual-edge data path: one serial line carrying a bit on every clock edge, rising and falling.
- Captures bits on both edges, hunts for a sync word, and assembles framed payload into WIDTH-bit parallel words.
- Delivers words on a single-edge valid/ready interface to downstream logic, which runs on rising edges only.

Parameters:
- WIDTH, 8, word width; even, >= 4.
- SYNC_WORD, 8'hA5, WIDTH-bit frame delimiter, MSB first.
- FRAME_WORDS, 4, payload words between consecutive sync words; >= 1.

Ports:
- clk  in  1  sole clock; data sampled on both edges.
- reset_n  in  1  asynchronous, active-low reset.
- din  in  1  serial DDR data.
- out_data  out  WIDTH  assembled payload word, MSB = earliest bit.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready at a rising edge.
- out_first  out  1  out_data is payload word 0 of a frame; qualified by out_valid.
- locked  out  1  frame alignment acquired.
- overflow  out  1  sticky; a completed word was dropped.
- sync_err_cnt  out  8  saturating count of missed sync words while locked.

Behaviour:
- Capture:
  - r_rise samples din on posedge.
  - r_fall samples din on negedge.
  - Each posedge shifts the pair {r_rise, r_fall} into a 2*WIDTH-bit shift register sr. r_rise is the older bit and lands above r_fall.
- Reset (async, reset_n=0): r_rise, r_fall, sr, all counters and all outputs go to 0; state returns to HUNT. Reset mid-word or mid-frame discards all partial data.
- State HUNT:
  - Each posedge compares sr[WIDTH-1:0] (phase 0) against SYNC_WORD.
  - On a match: latch phase, clear pair and word counters, go to LOCKED.
  - locked = 0. Nothing is emitted.
- State LOCKED:
  - locked = 1.
  - A word completes every WIDTH/2 posedges, taken from the aligned slice of sr.
  - Word slot index runs 0..FRAME_WORDS. Slots 0..FRAME_WORDS-1 are payload. Slot FRAME_WORDS is the expected sync word.
  - Sync slot matches SYNC_WORD: restart the frame. locked stays 1.
  - Sync slot mismatches: increment sync_err_cnt (saturates at 255), go to HUNT, locked = 0 on the next posedge.
- Output holding register (one deep):
  - A completed payload word loads out_data and out_first (1 for slot 0) and sets out_valid on the posedge after the word completes in sr.
  - Latency: out_valid rises on the 2nd posedge after the negedge that sampled the word's last bit.
  - Handshake: out_valid && out_ready clears out_valid unless a new word loads on the same edge; a new word loading on that edge wins.
  - A new word completes while out_valid=1 and out_ready=0: the word is dropped, overflow sets and stays set until reset, out_data is unchanged.
  - out_data/out_first hold while out_valid=1 && out_ready=0.
- Drop to HUNT does not flush a held word; the consumer may still take it.

Optional Feature:
- Macro DDR_DESER_ODD_ALIGN_EN.
- Defined:
  - HUNT also compares sr[WIDTH:1] (phase 1: sync starts on a falling-edge bit).
  - Phase 0 has priority if both match.
  - LOCKED extracts words at the latched phase.
- Undefined:
  - Only phase 0 is searched.
  - A stream aligned to phase 1 never locks.

Test Plan (WIDTH=8, SYNC_WORD=8'hA5, FRAME_WORDS=2, out_ready=1 unless stated):
- Reset: assert reset_n=0 between clock edges -> all outputs 0 immediately, no clock edge needed.
- Phase-0 frame: send A5,3C,C3,A5,11,22 -> locked rises after first A5; words 3C(first=1), C3(first=0), 11(first=1), 22 emitted; each out_valid on 2nd posedge after last-bit negedge; sync_err_cnt=0.
- Sync miss: send A5,3C,C3,FF -> sync_err_cnt=1, locked drops; a following A5,01,02 relocks and emits 01(first=1), 02.
- Backpressure: out_ready=0 through A5,3C,C3 -> out_data=3C held, overflow=1 when C3 completes; later reset clears overflow.
- Odd alignment: one leading pad bit, then A5,3C,C3 -> with DDR_DESER_ODD_ALIGN_EN: locks, emits 3C, C3; without: locked stays 0, no out_valid.
- Reset mid-frame: reset_n pulsed low during 3C -> state HUNT, out_valid=0, no partial word emitted afterwards.

Source files
------------

// File: rtl/ddr_deserializer.sv
// Dual-edge serial receiver: captures a bit on each clock edge, hunts for SYNC_WORD and
// emits framed WIDTH-bit payload words on a valid/ready port. Define DDR_DESER_ODD_ALIGN_EN to also search falling-edge alignment.
module ddr_deserializer #(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD  = 8'hA5,
    parameter int              FRAME_WORDS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             din,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_first,
    output logic             locked,
    output logic             overflow,
    output logic [7:0]       sync_err_cnt
);

    localparam int HALF = WIDTH / 2;
    localparam int PCW  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int WCW  = $clog2(FRAME_WORDS + 1);

    localparam logic [0:0] HUNT      = 1'b0;
    localparam logic [0:0] LOCKED_ST = 1'b1;

    logic                 r_rise;
    logic                 r_fall;
    logic [2*WIDTH-1:0]   sr;
    logic [0:0]           state;
    logic [PCW-1:0]       pcnt;
    logic [WCW-1:0]       wcnt;
    logic [WIDTH-1:0]     win0;
    logic [WIDTH-1:0]     word;
    logic                 unused_sr;

    assign win0      = sr[WIDTH-1:0];
    assign locked    = (state == LOCKED_ST);
    assign unused_sr = ^sr[2*WIDTH-1:WIDTH];

`ifdef DDR_DESER_ODD_ALIGN_EN
    logic             phase;
    logic [WIDTH-1:0] win1;
    assign win1 = sr[WIDTH:1];
    assign word = phase ? win1 : win0;
`else
    assign word = win0;
`endif

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fall <= 1'b0;
        end else begin
            r_fall <= din;
        end
    end

    // Pair counter lags sr by one edge, so a word is complete in sr when pcnt reaches HALF-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rise       <= 1'b0;
            sr           <= '0;
            state        <= HUNT;
            pcnt         <= '0;
            wcnt         <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_first    <= 1'b0;
            overflow     <= 1'b0;
            sync_err_cnt <= 8'd0;
`ifdef DDR_DESER_ODD_ALIGN_EN
            phase        <= 1'b0;
`endif
        end else begin
            r_rise <= din;
            sr     <= {sr[2*WIDTH-3:0], r_rise, r_fall};

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                HUNT: begin
                    if (win0 == SYNC_WORD) begin
                        state <= LOCKED_ST;
                        pcnt  <= '0;
                        wcnt  <= '0;
`ifdef DDR_DESER_ODD_ALIGN_EN
                        phase <= 1'b0;
                    end else if (win1 == SYNC_WORD) begin
                        state <= LOCKED_ST;
                        pcnt  <= '0;
                        wcnt  <= '0;
                        phase <= 1'b1;
`endif
                    end
                end
                default: begin
                    if (pcnt == PCW'(HALF - 1)) begin
                        pcnt <= '0;
                        if (wcnt == WCW'(FRAME_WORDS)) begin
                            if (word == SYNC_WORD) begin
                                wcnt <= '0;
                            end else begin
                                state <= HUNT;
                                if (sync_err_cnt != 8'hFF) begin
                                    sync_err_cnt <= sync_err_cnt + 8'd1;
                                end
                            end
                        end else begin
                            wcnt <= wcnt + WCW'(1);
                            // A stalled holding register keeps its word; the new one is lost.
                            if (out_valid && !out_ready) begin
                                overflow <= 1'b1;
                            end else begin
                                out_data  <= word;
                                out_first <= (wcnt == '0);
                                out_valid <= 1'b1;
                            end
                        end
                    end else begin
                        pcnt <= pcnt + PCW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_deserializer.sv
// Scoreboard bench for ddr_deserializer (WIDTH=8, SYNC_WORD=A5, FRAME_WORDS=2).
// The driver pushes expected words with their expected valid cycle; a negedge monitor pops and compares.
module tb_ddr_deserializer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       din;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_first;
    logic       locked;
    logic       overflow;
    logic [7:0] sync_err_cnt;

    typedef struct {
        logic [7:0] data;
        logic       first;
        int         cyc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

`ifdef DDR_DESER_ODD_ALIGN_EN
    localparam bit ODD_EN = 1'b1;
`else
    localparam bit ODD_EN = 1'b0;
`endif

    ddr_deserializer #(.WIDTH(8), .SYNC_WORD(8'hA5), .FRAME_WORDS(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .din          (din),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_first    (out_first),
        .locked       (locked),
        .overflow     (overflow),
        .sync_err_cnt (sync_err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Every accepted word must match the head of the scoreboard, including the cycle it appeared.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_word actual=%0h required=none", out_data);
            end else begin
                e = sbq.pop_front();
                checkOutput("word_data", {24'd0, out_data}, {24'd0, e.data});
                checkOutput("word_first", {31'd0, out_first}, {31'd0, e.first});
                if (e.cyc >= 0) checkOutput("word_latency", cycle, e.cyc);
            end
        end
    end

    task automatic sendBit(input logic b);
        @(clk);
        #1;
        din = b;
    endtask

    task automatic applyStimulus(input logic [7:0] w, input bit emit, input bit first);
        for (int i = 7; i >= 0; i--) sendBit(w[i]);
        if (emit) sbq.push_back('{w, first, cycle + (clk ? 2 : 3)});
    endtask

    task automatic idle(input int n);
        repeat (n) sendBit(1'b0);
    endtask

    task automatic doReset();
        reset_n   = 1'b0;
        din       = 1'b0;
        out_ready = 1'b1;
        sbq.delete();
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Phase-0 frame with lock timing observed around the first sync word.
        doReset();
        idle(4);
        applyStimulus(8'hA5, 0, 0);
        fork
            begin
                @(posedge clk); #1;
                checkOutput("lock_before", {31'd0, locked}, 32'd0);
                @(posedge clk); #1;
                checkOutput("lock_after", {31'd0, locked}, 32'd1);
            end
        join_none
        applyStimulus(8'h3C, 1, 1);
        applyStimulus(8'hC3, 1, 0);
        applyStimulus(8'hA5, 0, 0);
        applyStimulus(8'h11, 1, 1);
        applyStimulus(8'h22, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("frame_locked", {31'd0, locked}, 32'd1);
        checkOutput("frame_err_cnt", {24'd0, sync_err_cnt}, 32'd0);
        checkOutput("frame_drained", sbq.size(), 32'd0);

        // Missed sync word drops lock, then a fresh sync relocks.
        doReset();
        idle(4);
        applyStimulus(8'hA5, 0, 0);
        applyStimulus(8'h3C, 1, 1);
        applyStimulus(8'hC3, 1, 0);
        applyStimulus(8'hFF, 0, 0);
        fork
            begin
                @(posedge clk); #1;
                checkOutput("miss_still_locked", {31'd0, locked}, 32'd1);
                @(posedge clk); #1;
                checkOutput("miss_unlocked", {31'd0, locked}, 32'd0);
                checkOutput("miss_err_cnt", {24'd0, sync_err_cnt}, 32'd1);
            end
        join_none
        applyStimulus(8'hA5, 0, 0);
        applyStimulus(8'h01, 1, 1);
        applyStimulus(8'h02, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("relock", {31'd0, locked}, 32'd1);
        checkOutput("relock_err_cnt", {24'd0, sync_err_cnt}, 32'd1);
        checkOutput("relock_drained", sbq.size(), 32'd0);

        // Backpressure: first word held, second dropped with sticky overflow.
        doReset();
        out_ready = 1'b0;
        idle(4);
        applyStimulus(8'hA5, 0, 0);
        applyStimulus(8'h3C, 0, 0);
        applyStimulus(8'hC3, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_data", {24'd0, out_data}, 32'h3C);
        checkOutput("bp_first", {31'd0, out_first}, 32'd1);
        checkOutput("bp_overflow", {31'd0, overflow}, 32'd1);
        sbq.push_back('{8'h3C, 1'b1, -1});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_consumed", {31'd0, out_valid}, 32'd0);
        checkOutput("bp_overflow_sticky", {31'd0, overflow}, 32'd1);
        checkOutput("bp_drained", sbq.size(), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("bp_err_cnt", {24'd0, sync_err_cnt}, 32'd1);

        // Asynchronous reset between edges clears everything at once.
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_data", {24'd0, out_data}, 32'd0);
        checkOutput("rst_first", {31'd0, out_first}, 32'd0);
        checkOutput("rst_locked", {31'd0, locked}, 32'd0);
        checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("rst_err_cnt", {24'd0, sync_err_cnt}, 32'd0);

        // Sync starting on a falling-edge bit.
        doReset();
        idle(4);
        sendBit(1'b0);
        applyStimulus(8'hA5, 0, 0);
        applyStimulus(8'h3C, ODD_EN, 1);
        applyStimulus(8'hC3, ODD_EN, 0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("odd_locked", {31'd0, locked}, {31'd0, ODD_EN});
        checkOutput("odd_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("odd_drained", sbq.size(), 32'd0);

        // Reset in the middle of a payload word discards the partial frame.
        doReset();
        idle(4);
        applyStimulus(8'hA5, 0, 0);
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_locked", {31'd0, locked}, 32'd0);
        checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        reset_n = 1'b1;
        sendBit(1'b1);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b0);
        applyStimulus(8'hC3, 0, 0);
        idle(12);
        #1;
        checkOutput("mid_after_locked", {31'd0, locked}, 32'd0);
        checkOutput("mid_after_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("sb_empty", sbq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
